// File: rtl/flappy_audio_pkg.sv
// Purpose: shared note codes, pitch table, half-period helper and FSM encodings for the tone sequencer.
// Latency: n/a (constants and an elaboration-time helper function only).
// Backpressure: n/a.
package flappy_audio_pkg;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  // Pitch in Hz by note code: 1 G4 .. 14 E6; REST and END have no pitch.
  localparam int unsigned PITCH_HZ [16] = '{
    0, 392, 415, 440, 494, 523, 587, 659,
    698, 784, 880, 988, 1046, 1175, 1319, 0
  };

  // Half-period in clock cycles, truncated; 0 for codes without a pitch.
  function automatic int unsigned half_period(input logic [3:0] note, input int unsigned clk_hz);
    if (PITCH_HZ[note] == 0) return 0;
    return clk_hz / (2 * PITCH_HZ[note]);
  endfunction

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_DECODE = 3'd3;
  localparam state_t ST_PLAY   = 3'd4;

endpackage

// File: rtl/tone_sequencer_if.sv
// Purpose: control, song-ROM and audio signals between the player and its host.
// Latency: n/a (wires only).
// Backpressure: none; start/stop are single-cycle pulses, ROM data is fixed one cycle after address.
interface tone_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int TRACK_W = 2
);
  logic               start;
  logic [TRACK_W-1:0] track;
  logic               loop;
  logic               stop;
  logic               mute;
  logic [ADDR_W-1:0]  rom_addr;
  logic [7:0]         rom_data;
  logic               beep;
  logic               busy;
  logic               done;

  modport master (
    output start, track, loop, stop, mute, rom_data,
    input  rom_addr, beep, busy, done
  );

  modport slave (
    input  start, track, loop, stop, mute, rom_data,
    output rom_addr, beep, busy, done
  );
endinterface

// File: rtl/tone_gen.sv
// Purpose: square-wave pitch divider for one note code; REST gives a constant low output.
// Latency: first toggle HP cycles after run rises; output forced low the cycle after run drops.
// Backpressure: none.
module tone_gen
  import flappy_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       run,
  input  logic [3:0] note,
  output logic       beep_raw
);

  // G4 is the lowest pitch, so its half-period sizes the counter.
  localparam int unsigned HP_MAX = half_period(4'h1, CLK_HZ);
  localparam int          HP_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

  logic [3:0]      note_r;
  logic [HP_W-1:0] cnt;
  logic [HP_W-1:0] hp_m1 [16];

  // Terminal counts are constants; entries for REST/END are never consulted.
  for (genvar g = 0; g < 16; g++) begin : g_hp
    assign hp_m1[g] = HP_W'(half_period(4'(g), CLK_HZ) - 1);
  end

  // Divider: count 0..HP-1 and toggle at the wrap; idle or rest holds the line low.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_r   <= NOTE_REST;
      cnt      <= '0;
      beep_raw <= 1'b0;
    end else begin
      if (load) note_r <= note;
      if (!run || note_r == NOTE_REST) begin
        cnt      <= '0;
        beep_raw <= 1'b0;
      end else if (cnt == hp_m1[note_r]) begin
        cnt      <= '0;
        beep_raw <= ~beep_raw;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Purpose: melody/effect player walking song-ROM entries {dur, note} and driving a square-wave beep.
// Latency: 3-cycle silent gap between notes (FETCH, WAIT, DECODE); start/stop act on the next edge.
// Backpressure: none; stop beats start, start preempts anything in progress.
module tone_sequencer
  import flappy_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 16,
  parameter int          ADDR_W  = 8,
  parameter int          TRACK_W = 2
) (
  input logic             clk,
  input logic             rst,
  tone_sequencer_if.slave bus
);

  localparam int unsigned      TICK_P    = CLK_HZ / TICK_HZ;
  localparam int               TK_W      = (TICK_P > 1) ? $clog2(TICK_P) : 1;
  localparam logic [TK_W-1:0]  TICK_LAST = TK_W'(TICK_P - 1);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [ADDR_W-1:0] new_base;
  logic              loop_r;
  logic              done_r;
  logic [7:0]        entry;
  logic [3:0]        e_note;
  logic [3:0]        e_dur;
  logic [4:0]        dur_cnt;
  logic [TK_W-1:0]   tick_cnt;
  logic              last_tick;
  logic              run;
  logic              load;
  logic              beep_raw;

  assign e_note    = entry[3:0];
  assign e_dur     = entry[7:4];
  assign new_base  = ADDR_W'(bus.track) << (ADDR_W - TRACK_W);
  assign last_tick = (tick_cnt == TICK_LAST) && (dur_cnt == 5'd1);
  // The tone keeps running only while PLAY continues past this edge.
  assign run       = (state == ST_PLAY) && !bus.stop && !bus.start && !last_tick;
  assign load      = (state == ST_DECODE) && !bus.stop && !bus.start && (e_note != NOTE_END);

  tone_gen #(.CLK_HZ(CLK_HZ)) u_tone (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .run      (run),
    .note     (e_note),
    .beep_raw (beep_raw)
  );

  // Sequencer FSM with stop > start > normal stepping; also owns tick and duration counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      base       <= '0;
      rom_addr_r <= '0;
      loop_r     <= 1'b0;
      done_r     <= 1'b0;
      entry      <= '0;
      dur_cnt    <= '0;
      tick_cnt   <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.stop) begin
        state <= ST_IDLE;
      end else if (bus.start) begin
        base       <= new_base;
        rom_addr_r <= new_base;
        loop_r     <= bus.loop;
        state      <= ST_FETCH;
      end else begin
        case (state)
          ST_FETCH: state <= ST_WAIT;
          ST_WAIT: begin
            entry <= bus.rom_data;
            state <= ST_DECODE;
          end
          ST_DECODE: begin
            if (e_note == NOTE_END) begin
              if (loop_r) begin
                rom_addr_r <= base;
                state      <= ST_FETCH;
              end else begin
                done_r <= 1'b1;
                state  <= ST_IDLE;
              end
            end else begin
              dur_cnt  <= (e_dur == 4'd0) ? 5'd16 : {1'b0, e_dur};
              tick_cnt <= '0;
              state    <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (dur_cnt == 5'd1) begin
                // Address wraps across the whole ROM, not just the track.
                rom_addr_r <= rom_addr_r + ADDR_W'(1);
                state      <= ST_FETCH;
              end else begin
                dur_cnt <= dur_cnt - 5'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TK_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_r;
  assign bus.beep     = beep_raw & ~bus.mute;

endmodule

// File: tb/tb_tone_sequencer.sv
// Purpose: directed self-checking bench for tone_sequencer with a one-cycle synchronous ROM model.
// Latency: tick = 1000 cycles here; A4 half-period 113, C5 half-period 95.
// Backpressure: n/a.
module tb_tone_sequencer;

  localparam int unsigned CLK_HZ  = 100_000;
  localparam int unsigned TICK_HZ = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tone_sequencer_if #(.ADDR_W(8), .TRACK_W(2)) bus ();

  tone_sequencer #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .ADDR_W (8),
    .TRACK_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];

  // Synchronous song ROM: data valid one cycle after the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   hi_cnt = 0;
  int   tog_cnt = 0;
  logic prev_beep = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done) done_cnt++;
    if (bus.beep) hi_cnt++;
    if (bus.beep !== prev_beep) tog_cnt++;
    prev_beep = bus.beep;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    done_cnt = 0;
    hi_cnt   = 0;
    tog_cnt  = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [1:0] trk, input logic lp);
    bus.track = trk;
    bus.loop  = lp;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mute  = 1'b0;
    bus.track = 2'd0;
    bus.loop  = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h0F;

    // Reset state
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_beep", 32'(bus.beep), 0);
    check("rst_addr", 32'(bus.rom_addr), 0);

    // 1: A4 for one tick, then END without loop
    rom[0] = 8'h13;
    rom[1] = 8'h0F;
    go(2'd0, 1'b0);
    check("t1_addr0", 32'(bus.rom_addr), 0);
    check("t1_busy", 32'(bus.busy), 1);
    ticks(3);
    clr();
    check("t1_play_lo", 32'(bus.beep), 0);
    ticks(112);
    check("t1_hp_m1", 32'(bus.beep), 0);
    tick();
    check("t1_hp", 32'(bus.beep), 1);
    ticks(113);
    check("t1_2hp", 32'(bus.beep), 0);
    ticks(773);
    check("t1_last_addr", 32'(bus.rom_addr), 0);
    check("t1_toggles", 32'(tog_cnt), 8);
    tick();
    check("t1_next_addr", 32'(bus.rom_addr), 1);
    check("t1_gap_beep", 32'(bus.beep), 0);
    ticks(2);
    check("t1_pre_done", 32'(bus.done), 0);
    check("t1_pre_busy", 32'(bus.busy), 1);
    tick();
    check("t1_done", 32'(bus.done), 1);
    check("t1_busy_fall", 32'(bus.busy), 0);
    tick();
    check("t1_done_1cyc", 32'(bus.done), 0);
    check("t1_done_cnt", 32'(done_cnt), 1);

    // 2: rest with dur 0 lasts 16 ticks
    rom[0] = 8'h00;
    go(2'd0, 1'b0);
    ticks(3);
    clr();
    ticks(15999);
    check("t2_last_addr", 32'(bus.rom_addr), 0);
    check("t2_busy", 32'(bus.busy), 1);
    tick();
    check("t2_next_addr", 32'(bus.rom_addr), 1);
    ticks(2);
    check("t2_pre_done", 32'(bus.done), 0);
    tick();
    check("t2_done", 32'(bus.done), 1);
    check("t2_beep_silent", 32'(hi_cnt), 0);

    // 3: looped track 1, C5 for two ticks
    rom[8'h40] = 8'h25;
    rom[8'h41] = 8'h0F;
    go(2'd1, 1'b1);
    check("t3_base", 32'(bus.rom_addr), 32'h40);
    ticks(3);
    clr();
    ticks(94);
    check("t3_hp_m1", 32'(bus.beep), 0);
    tick();
    check("t3_hp", 32'(bus.beep), 1);
    ticks(1905);
    check("t3_end_addr", 32'(bus.rom_addr), 32'h41);
    ticks(3);
    check("t3_reload", 32'(bus.rom_addr), 32'h40);
    check("t3_busy", 32'(bus.busy), 1);
    check("t3_no_done", 32'(bus.done), 0);
    ticks(98);
    check("t3_iter2_hp", 32'(bus.beep), 1);
    ticks(7929);
    check("t3_iter6_addr", 32'(bus.rom_addr), 32'h40);
    check("t3_done_cnt", 32'(done_cnt), 0);
    check("t3_toggles", 32'(tog_cnt), 110);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("t3_stop_busy", 32'(bus.busy), 0);
    check("t3_stop_beep", 32'(bus.beep), 0);
    check("t3_stop_done", 32'(bus.done), 0);

    // 4: start track 2 preempts a sounding note
    rom[0]     = 8'h13;
    rom[8'h80] = 8'h0F;
    go(2'd0, 1'b0);
    ticks(116);
    check("t4_sounding", 32'(bus.beep), 1);
    clr();
    go(2'd2, 1'b0);
    check("t4_addr", 32'(bus.rom_addr), 32'h80);
    check("t4_beep", 32'(bus.beep), 0);
    check("t4_busy", 32'(bus.busy), 1);
    ticks(2);
    check("t4_pre_done", 32'(bus.done), 0);
    tick();
    check("t4_done", 32'(bus.done), 1);
    check("t4_done_cnt", 32'(done_cnt), 1);

    // 5: stop beats start; stop during WAIT
    bus.track = 2'd1;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t5_both_busy", 32'(bus.busy), 0);
    ticks(3);
    check("t5_both_busy3", 32'(bus.busy), 0);
    check("t5_both_addr", 32'(bus.rom_addr), 32'h80);
    go(2'd0, 1'b0);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("t5_wait_busy", 32'(bus.busy), 0);
    clr();
    ticks(4);
    check("t5_wait_idle", 32'(bus.busy), 0);
    check("t5_wait_nodone", 32'(done_cnt), 0);

    // 6: mute mid-note, then reset mid-note
    go(2'd0, 1'b0);
    ticks(116);
    check("t6_sounding", 32'(bus.beep), 1);
    bus.mute = 1'b1;
    tick();
    check("t6_muted", 32'(bus.beep), 0);
    ticks(225);
    check("t6_muted_hi", 32'(bus.beep), 0);
    bus.mute = 1'b0;
    tick();
    check("t6_unmuted", 32'(bus.beep), 1);
    ticks(659);
    check("t6_last_addr", 32'(bus.rom_addr), 0);
    tick();
    check("t6_next_addr", 32'(bus.rom_addr), 1);
    ticks(3);
    check("t6_done", 32'(bus.done), 1);

    go(2'd0, 1'b0);
    ticks(116);
    check("t6_pre_rst", 32'(bus.beep), 1);
    rst = 1'b1;
    tick();
    check("t6_rst_beep", 32'(bus.beep), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_done", 32'(bus.done), 0);
    check("t6_rst_addr", 32'(bus.rom_addr), 0);
    rst = 1'b0;
    ticks(5);
    check("t6_post_busy", 32'(bus.busy), 0);
    check("t6_post_addr", 32'(bus.rom_addr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
